alu_command_master: RTL and testbench
=====================================

# alu_command_master

Host-side initiator for the UART ALU protocol. Given operands and an opcode, it sends three bytes (A, B, OPCODE) through a byte-level UART transmitter, then waits for the single result byte from the UART receiver. It sits between a user/test controller and the `uart_tx`/`uart_rx` byte modules, and drives the serial link toward the board-side ALU interface circuit.

## Interface
Parameters:
- `LEN_DATA`, 8: byte width of the link, operands and result.
- `LEN_OP`, 6: opcode width; must be ≤ `LEN_DATA`.
- `TIMEOUT_CYCLES`, 1000000: clocks allowed in WAIT_RES before aborting; 0 disables the timeout.

Ports:
- `clk`  in  1: clock; all logic on posedge.
- `reset`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request a transaction; sampled only in IDLE.
- `a_in`  in  `LEN_DATA`: operand A.
- `b_in`  in  `LEN_DATA`: operand B.
- `op_in`  in  `LEN_OP`: ALU opcode.
- `tx_done_tick`  in  1: one-cycle pulse from uart_tx when a byte has finished.
- `rx_done_tick`  in  1: one-cycle pulse from uart_rx when a byte has been received.
- `rx_data_in`  in  `LEN_DATA`: received byte; valid when `rx_done_tick`=1.
- `tx_start`  out  1: one-cycle pulse that starts uart_tx.
- `tx_data_out`  out  `LEN_DATA`: byte to transmit; held stable from the `tx_start` pulse until `tx_done_tick`.
- `busy`  out  1: high from start acceptance until the transaction completes or aborts.
- `result`  out  `LEN_DATA`: last received result byte.
- `result_valid`  out  1: one-cycle pulse when `result` updates.
- `timeout`  out  1: one-cycle pulse when a transaction is aborted because no result arrived.

## Operation
- All outputs are registered. Reset values: `tx_start`=0, `tx_data_out`=0, `busy`=0, `result`=0, `result_valid`=0, `timeout`=0. Reset puts the FSM in IDLE and clears the timeout counter.
- Reset in the middle of a transaction aborts it immediately. No pulse is emitted, and the partially sent sequence is not resumed.
- States: IDLE, WAIT_A, WAIT_B, WAIT_OP, WAIT_RES.
- IDLE, when `start`=1:
  - latch `a_in`, `b_in`, `op_in` into internal registers;
  - set `tx_data_out`=A, `tx_start`=1, `busy`=1;
  - go to WAIT_A.
- The latched copies are used for the whole transaction. Input changes after acceptance have no effect.
- WAIT_A, on `tx_done_tick`: `tx_data_out`=B, `tx_start`=1, go to WAIT_B.
- WAIT_B, on `tx_done_tick`: `tx_data_out`={zeros, OP} (opcode zero-extended to `LEN_DATA`), `tx_start`=1, go to WAIT_OP.
- WAIT_OP, on `tx_done_tick`: clear the timeout counter, go to WAIT_RES.
- WAIT_RES, on `rx_done_tick`: `result`=`rx_data_in`, `result_valid`=1, `busy`=0, go to IDLE.
- WAIT_RES with no `rx_done_tick` and `TIMEOUT_CYCLES`≠0: the counter increments each clock. When it reaches `TIMEOUT_CYCLES`-1: `timeout`=1, `busy`=0, go to IDLE; `result` is unchanged.
- `tx_start` is 0 in every cycle except those listed above, where it is set for exactly one cycle.
- Ignored events:
  - `start` outside IDLE;
  - `tx_done_tick` outside WAIT_A/B/OP;
  - `rx_done_tick` outside WAIT_RES (stray bytes are dropped).
- Timeout counter width: `$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit. It saturates and does not wrap.

## Timing
- `tx_start` is asserted in the cycle after the edge at which `start` was sampled, or after the edge at which `tx_done_tick` was sampled (1-cycle latency). `tx_data_out` is valid in that same cycle.
- Minimum transaction length: 1 + 3·(uart_tx byte time) + receive time + 1 cycle.
- `result_valid`/`busy` fall: in the cycle after `rx_done_tick` is sampled, `result_valid`=1 and `busy`=0.
- Simultaneous `rx_done_tick` and timeout expiry in the same cycle: the result wins. `result_valid`=1, `timeout` stays 0.
- A new `start` is accepted in the cycle where `result_valid` or `timeout` is high, because the FSM is already in IDLE. Back-to-back transactions are therefore possible.
- A `tx_done_tick` in the same cycle as the `tx_start` it answers cannot occur with uart_tx and is not supported.

## Test plan
- Reset values: assert `reset` asynchronously mid-cycle → all outputs 0 immediately, FSM in IDLE; `start` one cycle after release is accepted.
- Basic transaction: A=0x05, B=0x03, OP=6'h20.
  - Required byte sequence on `tx_data_out` at the three `tx_start` pulses: 0x05, 0x03, 0x20.
  - Reply 0x08 via `rx_done_tick` → `result`=0x08 with a one-cycle `result_valid`; `busy` low in that cycle.
- Input stability and ignored events:
  - change `a_in` to 0xFF and pulse `start` while in WAIT_B → bytes sent are unchanged;
  - `rx_done_tick` with 0x55 during WAIT_A → ignored, `result` unchanged.
- Timeout: `TIMEOUT_CYCLES`=16, send all three bytes, never reply → `timeout` pulses 16 cycles after entering WAIT_RES, `busy`=0, `result` keeps its old value. A late `rx_done_tick` is then ignored.
- Race: with `TIMEOUT_CYCLES`=16, drive `rx_done_tick` (0xA5) in the expiry cycle → `result`=0xA5, `result_valid`=1, `timeout`=0.
- Back-to-back and abort:
  - hold `start`=1 continuously → a second transaction starts in the `result_valid` cycle;
  - assert `reset` during WAIT_OP → no further `tx_start`, `busy`=0.

Source files
------------

// File: rtl/alu_command_master_if.sv
// Bundle of user-side request/response and uart_tx/uart_rx byte handshake signals
// for alu_command_master.
interface alu_command_master_if #(
  parameter int unsigned LEN_DATA = 8,
  parameter int unsigned LEN_OP   = 6
);
  logic                start;
  logic [LEN_DATA-1:0] a_in;
  logic [LEN_DATA-1:0] b_in;
  logic [LEN_OP-1:0]   op_in;
  logic                tx_done_tick;
  logic                rx_done_tick;
  logic [LEN_DATA-1:0] rx_data_in;
  logic                tx_start;
  logic [LEN_DATA-1:0] tx_data_out;
  logic                busy;
  logic [LEN_DATA-1:0] result;
  logic                result_valid;
  logic                timeout;

  modport master (
    input  start, a_in, b_in, op_in, tx_done_tick, rx_done_tick, rx_data_in,
    output tx_start, tx_data_out, busy, result, result_valid, timeout
  );

  modport slave (
    output start, a_in, b_in, op_in, tx_done_tick, rx_done_tick, rx_data_in,
    input  tx_start, tx_data_out, busy, result, result_valid, timeout
  );
endinterface

// File: rtl/alu_command_master.sv
// Host-side UART ALU initiator: sends A, B, OPCODE through uart_tx, then waits
// for one result byte from uart_rx, with an optional reply timeout.
module alu_command_master #(
  parameter int unsigned LEN_DATA       = 8,
  parameter int unsigned LEN_OP         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_command_master_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    StIdle,
    StWaitA,
    StWaitB,
    StWaitOp,
    StWaitRes
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_DATA-1:0] a_q, a_d;
  logic [LEN_DATA-1:0] b_q, b_d;
  logic [LEN_OP-1:0]   op_q, op_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tx_start_q, tx_start_d;
  logic [LEN_DATA-1:0] tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic [LEN_DATA-1:0] result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                timeout_q, timeout_d;

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    busy_d         = busy_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d        = bus.a_in;
          b_d        = bus.b_in;
          op_d       = bus.op_in;
          tx_data_d  = bus.a_in;
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = StWaitA;
        end
      end
      StWaitA: begin
        if (bus.tx_done_tick) begin
          tx_data_d  = b_q;
          tx_start_d = 1'b1;
          state_d    = StWaitB;
        end
      end
      StWaitB: begin
        if (bus.tx_done_tick) begin
          tx_data_d  = LEN_DATA'(op_q);
          tx_start_d = 1'b1;
          state_d    = StWaitOp;
        end
      end
      StWaitOp: begin
        if (bus.tx_done_tick) begin
          cnt_d   = '0;
          state_d = StWaitRes;
        end
      end
      StWaitRes: begin
        // A result arriving in the expiry cycle takes priority over the timeout.
        if (bus.rx_done_tick) begin
          result_d       = bus.rx_data_in;
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
          state_d        = StIdle;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else if (TimeoutEn && (cnt_q != {CntW{1'b1}})) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      cnt_q          <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data_out  = tx_data_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_alu_command_master.sv
// Randomized self-checking bench for alu_command_master with a byte-queue reference
// model of the A/B/OPCODE sequence and the result/timeout rules.
module tb_alu_command_master;

  localparam int unsigned Tmo = 16;

  logic clk;
  logic reset;

  alu_command_master_if #(.LEN_DATA(8), .LEN_OP(6)) bus ();

  alu_command_master #(
    .LEN_DATA      (8),
    .LEN_OP        (6),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_sent   = 8'h00;
  logic [7:0] model_result = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every tx_start pulse must carry the next byte the model expects.
  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("tx_spurious", bus.tx_start, 0);
      end else begin
        last_sent = exp_q.pop_front();
        check_eq("tx_byte", bus.tx_data_out, last_sent);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_txs"}, bus.tx_start, 0);
    check_eq({tag, "_txd"}, bus.tx_data_out, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_res"}, bus.result, 0);
    check_eq({tag, "_rv"}, bus.result_valid, 0);
    check_eq({tag, "_tmo"}, bus.timeout, 0);
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.op_in = op;
    bus.start = 1'b1;
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back({2'b00, op});
    step();
    bus.start = 1'b0;
    check_eq("acc_txs", bus.tx_start, 1);
    check_eq("acc_busy", bus.busy, 1);
    check_eq("acc_rv", bus.result_valid, 0);
  endtask

  // Acknowledge n bytes; gaps may carry ignored start/rx_done and operand changes.
  task automatic send_bytes(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(1, 4);
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          bus.a_in         = 8'($urandom);
          bus.b_in         = 8'($urandom);
          bus.op_in        = 6'($urandom);
          bus.start        = ($urandom_range(0, 2) == 0);
          bus.rx_done_tick = ($urandom_range(0, 2) == 0);
          bus.rx_data_in   = 8'($urandom);
        end
        step();
        check_eq("gap_rv", bus.result_valid, 0);
        check_eq("gap_res", bus.result, model_result);
        check_eq("gap_txs", bus.tx_start, 0);
        check_eq("gap_txd", bus.tx_data_out, last_sent);
        check_eq("gap_busy", bus.busy, 1);
      end
      bus.start        = 1'b0;
      bus.rx_done_tick = 1'b0;
      bus.tx_done_tick = 1'b1;
      step();
      bus.tx_done_tick = 1'b0;
      check_eq("ack_txs", bus.tx_start, (i < 2) ? 1 : 0);
    end
  endtask

  task automatic reply(input int delay, input logic [7:0] data, input bit hold);
    for (int i = 0; i < delay; i++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a_in  = 8'($urandom);
      step();
      check_eq("wres_rv", bus.result_valid, 0);
      check_eq("wres_tmo", bus.timeout, 0);
      check_eq("wres_busy", bus.busy, 1);
    end
    bus.start        = hold;
    bus.rx_data_in   = data;
    bus.rx_done_tick = 1'b1;
    step();
    bus.rx_done_tick = 1'b0;
    model_result     = data;
    check_eq("rep_rv", bus.result_valid, 1);
    check_eq("rep_res", bus.result, model_result);
    check_eq("rep_busy", bus.busy, 0);
    check_eq("rep_tmo", bus.timeout, 0);
    if (!hold) begin
      bus.start = 1'b0;
      step();
      check_eq("post_rv", bus.result_valid, 0);
      check_eq("post_busy", bus.busy, 0);
      check_eq("post_res", bus.result, model_result);
    end
  endtask

  task automatic expect_timeout();
    for (int i = 1; i < Tmo; i++) begin
      step();
      check_eq("tw_tmo", bus.timeout, 0);
      check_eq("tw_busy", bus.busy, 1);
    end
    step();
    check_eq("tmo_pulse", bus.timeout, 1);
    check_eq("tmo_busy", bus.busy, 0);
    check_eq("tmo_rv", bus.result_valid, 0);
    check_eq("tmo_res", bus.result, model_result);
    bus.rx_done_tick = 1'b1;
    bus.rx_data_in   = 8'($urandom);
    step();
    bus.rx_done_tick = 1'b0;
    check_eq("late_rv", bus.result_valid, 0);
    check_eq("late_tmo", bus.timeout, 0);
    check_eq("late_res", bus.result, model_result);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.a_in         = '0;
    bus.b_in         = '0;
    bus.op_in        = '0;
    bus.tx_done_tick = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data_in   = '0;
    #1;
    check_all_zero("rst0");
    #11;
    reset = 1'b0;

    // Basic directed transaction with noise in the byte gaps.
    accept(8'h05, 8'h03, 6'h20);
    send_bytes(3, 1'b1);
    reply(2, 8'h08, 1'b0);

    // Asynchronous mid-cycle reset while waiting for the result.
    accept(8'h9C, 8'h41, 6'h2A);
    send_bytes(3, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    exp_q.delete();
    model_result = 8'h00;
    last_sent    = 8'h00;
    #2;
    reset = 1'b0;
    accept(8'h11, 8'h22, 6'h3F);
    send_bytes(3, 1'b1);
    reply(0, 8'h33, 1'b0);

    // Timeout without reply, then the result/expiry race.
    accept(8'h01, 8'h02, 6'h03);
    send_bytes(3, 1'b1);
    expect_timeout();
    accept(8'h7E, 8'h81, 6'h15);
    send_bytes(3, 1'b0);
    reply(Tmo - 1, 8'hA5, 1'b0);

    // Back-to-back: start held through the result_valid cycle.
    accept(8'hC3, 8'h3C, 6'h01);
    send_bytes(3, 1'b0);
    reply(1, 8'h5A, 1'b1);
    accept(8'hDE, 8'hAD, 6'h2F);
    send_bytes(3, 1'b1);
    reply(3, 8'hE7, 1'b0);

    // Reset during WAIT_OP abandons the transaction.
    accept(8'h44, 8'h55, 6'h26);
    send_bytes(2, 1'b0);
    step();
    reset = 1'b1;
    #1;
    check_eq("abort_busy", bus.busy, 0);
    exp_q.delete();
    model_result = 8'h00;
    last_sent    = 8'h00;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.tx_done_tick = (i % 2 == 0);
      step();
      check_eq("abort_txs", bus.tx_start, 0);
      check_eq("abort_busy2", bus.busy, 0);
    end
    bus.tx_done_tick = 1'b0;

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      int mode;
      accept(8'($urandom), 8'($urandom), 6'($urandom));
      send_bytes(3, 1'b1);
      mode = $urandom_range(0, 7);
      if (mode == 0) begin
        expect_timeout();
      end else if (mode == 1) begin
        reply(Tmo - 1, 8'($urandom), 1'b0);
      end else begin
        reply($urandom_range(0, Tmo - 2), 8'($urandom), 1'b0);
      end
    end

    step();
    check_eq("txq_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
